if_id_fetch: RTL and testbench

- Fetch-side stage directly downstream of the PC register.
- Takes PCF, issues a req/ack read to instruction memory, and produces PCPlus4F for the PC-select mux.
- Owns the IF/ID pipeline register (InstrD, PCPlus4D, ValidD), with decode-stage stall and flush.
- Raises FetchStall to the hazard unit while a memory read is outstanding.

---
 rtl/if_id_fetch.sv | 192 +++++++++++++++++++
 tb/tb_if_id_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// if_id_fetch: drives the instruction-memory req/ack read for PCF and owns the IF/ID pipeline register.
// Latency: an acked word reaches InstrD on the next clk edge, or on the edge after StallD releases if it was parked.
// Backpressure: FetchStall freezes PCF while a read is pending, parked or being dropped; StallD holds IF/ID.
module if_id_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        FetchStall,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        imem_err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // FETCH: a request for PCF is on the bus.
    // HOLD : a word arrived while decode was stalled and is parked locally.
    // DROP : a flushed request is still outstanding; its data will be thrown away.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_hold;
    logic             in_drop;
    logic             in_fetch;

    logic [31:0]      drop_addr;
    logic [31:0]      hold_instr;
    logic [31:0]      hold_pcp4;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    logic             ifid_load_mem;
    logic             ifid_load_hold;
    logic             ifid_bubble;
    logic             hold_capture;
    logic             drop_capture;

    // The unused encoding behaves as FETCH so a corrupted state recovers by itself.
    assign in_hold  = (state == ST_HOLD);
    assign in_drop  = (state == ST_DROP);
    assign in_fetch = !in_hold && !in_drop;

    // Fetch-side combinational outputs; the request is gated by reset so nothing is issued while it is held low.
    always_comb begin
        PCPlus4F   = PCF + 32'd4;
        imem_req   = reset && !in_hold;
        imem_addr  = in_drop ? drop_addr : PCF;
        // A flush in FETCH lets the PC take the redirect target on this edge.
        FetchStall = (in_fetch && !imem_ack && !FlushD) || in_hold || in_drop;
    end

    // Next-state and IF/ID update decisions; FlushD beats StallD beats a normal load.
    always_comb begin
        state_nxt      = state;
        ifid_load_mem  = 1'b0;
        ifid_load_hold = 1'b0;
        ifid_bubble    = 1'b0;
        hold_capture   = 1'b0;
        drop_capture   = 1'b0;
        case (state)
            ST_HOLD: begin
                if (FlushD) begin
                    ifid_bubble = 1'b1;
                    state_nxt   = ST_FETCH;
                end else if (!StallD) begin
                    ifid_load_hold = 1'b1;
                    state_nxt      = ST_FETCH;
                end
            end
            ST_DROP: begin
                // Another flush changes nothing here: the dropped address is already latched.
                if (FlushD || !StallD) begin
                    ifid_bubble = 1'b1;
                end
                if (imem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
                if (FlushD) begin
                    ifid_bubble = 1'b1;
                    if (!imem_ack) begin
                        // The request cannot be withdrawn, so finish it at the old address.
                        drop_capture = 1'b1;
                        state_nxt    = ST_DROP;
                    end
                end else if (StallD) begin
                    if (imem_ack) begin
                        hold_capture = 1'b1;
                        state_nxt    = ST_HOLD;
                    end
                end else if (imem_ack) begin
                    ifid_load_mem = 1'b1;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
        endcase
    end

    // Wait counter: counts unanswered request cycles, saturating at TIMEOUT.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (imem_req && !imem_ack) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt_nxt = wait_cnt + 1'b1;
            end
        end else if (imem_ack || (state_nxt == ST_FETCH && !in_fetch)) begin
            wait_cnt_nxt = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter and sticky timeout flag; only reset clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            imem_err <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if (wait_cnt_nxt == CNT_MAX) begin
                imem_err <= 1'b1;
            end
        end
    end

    // Address of a flushed-but-outstanding request, replayed on the bus while dropping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_addr <= 32'd0;
        end else if (drop_capture) begin
            drop_addr <= PCF;
        end
    end

    // Parking register for a word that arrived while decode was stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_instr <= 32'd0;
            hold_pcp4  <= 32'd0;
        end else if (hold_capture) begin
            hold_instr <= imem_rdata;
            hold_pcp4  <= PCPlus4F;
        end
    end

    // IF/ID pipeline register; a bubble leaves PCPlus4D untouched since ValidD=0 marks it meaningless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (ifid_bubble) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (ifid_load_mem) begin
            InstrD   <= imem_rdata;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end else if (ifid_load_hold) begin
            InstrD   <= hold_instr;
            PCPlus4D <= hold_pcp4;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: directed scenarios plus a randomized run against a transaction-level model.
// Latency: checks registered outputs one edge after the inputs that caused them.
// Backpressure: the bench acts as PC register and instruction memory with random latency.
module tb_if_id_fetch;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int          TMO     = 16;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        FlushD;
    logic        FetchStall;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        imem_err;

    int n_checks = 0;
    int n_pass   = 0;

    if_id_fetch #(.NOP_INSTR(NOP), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FetchStall (FetchStall),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .imem_err   (imem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs.
    task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                         input logic st, input logic fl);
        PCF        = pc;
        imem_ack   = ack;
        imem_rdata = rd;
        StallD     = st;
        FlushD     = fl;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        n_checks++; if (InstrD !== NOP) $display("FAIL rst_instr got %h want %h", InstrD, NOP); else n_pass++;
        n_checks++; if (PCPlus4D !== 32'h0) $display("FAIL rst_pcp4 got %h want 0", PCPlus4D); else n_pass++;
        n_checks++; if (ValidD !== 1'b0) $display("FAIL rst_valid got %b want 0", ValidD); else n_pass++;
        n_checks++; if (imem_err !== 1'b0) $display("FAIL rst_err got %b want 0", imem_err); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
        next_edge();
        reset = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        logic [31:0] rd;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            rd = 32'h2008_0001 + 32'(i);
            drive(pc, 1'b1, rd, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++; if (FetchStall !== 1'b0) $display("FAIL zw_fstall[%0d] got %b want 0", i, FetchStall); else n_pass++;
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== pc) $display("FAIL zw_req[%0d] got %b/%h want 1/%h", i, imem_req, imem_addr, pc); else n_pass++;
            n_checks++; if (PCPlus4F !== pc + 32'd4) $display("FAIL zw_pcp4f[%0d] got %h want %h", i, PCPlus4F, pc + 32'd4); else n_pass++;
            next_edge();
            n_checks++; if (InstrD !== rd || PCPlus4D !== pc + 32'd4 || ValidD !== 1'b1)
                $display("FAIL zw_ifid[%0d] got %h/%h/%b want %h/%h/1", i, InstrD, PCPlus4D, ValidD, rd, pc + 32'd4); else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++; if (FetchStall !== 1'b1) $display("FAIL ws_fstall[%0d] got %b want 1", i, FetchStall); else n_pass++;
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL ws_addr[%0d] got %b/%h want 1/00000040", i, imem_req, imem_addr); else n_pass++;
            next_edge();
            n_checks++; if (ValidD !== 1'b0) $display("FAIL ws_bubble[%0d] got %b want 0", i, ValidD); else n_pass++;
        end
        drive(32'h40, 1'b1, 32'hDEAD_0040, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (FetchStall !== 1'b0) $display("FAIL ws_fstall_ack got %b want 0", FetchStall); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'hDEAD_0040 || PCPlus4D !== 32'h44 || ValidD !== 1'b1)
            $display("FAIL ws_ifid got %h/%h/%b want dead0040/00000044/1", InstrD, PCPlus4D, ValidD); else n_pass++;
    endtask

    task automatic test_stall_on_ack();
        drive(32'h10, 1'b1, 32'h1111_0010, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (FetchStall !== 1'b0) $display("FAIL sa_fstall_ack got %b want 0", FetchStall); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'hDEAD_0040 || ValidD !== 1'b1) $display("FAIL sa_hold0 got %h/%b want dead0040/1", InstrD, ValidD); else n_pass++;
        drive(32'h14, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || FetchStall !== 1'b1) $display("FAIL sa_hold_req got %b/%b want 0/1", imem_req, FetchStall); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'hDEAD_0040) $display("FAIL sa_hold1 got %h want dead0040", InstrD); else n_pass++;
        drive(32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL sa_release_req got %b want 0", imem_req); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'h1111_0010 || PCPlus4D !== 32'h14 || ValidD !== 1'b1)
            $display("FAIL sa_release got %h/%h/%b want 11110010/00000014/1", InstrD, PCPlus4D, ValidD); else n_pass++;
        drive(32'h14, 1'b1, 32'h2222_0014, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) $display("FAIL sa_next_req got %b/%h want 1/00000014", imem_req, imem_addr); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'h2222_0014 || PCPlus4D !== 32'h18) $display("FAIL sa_next got %h/%h want 22220014/00000018", InstrD, PCPlus4D); else n_pass++;
    endtask

    task automatic test_flush_during_wait();
        drive(32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (FetchStall !== 1'b0) $display("FAIL fw_fstall_flush got %b want 0", FetchStall); else n_pass++;
        next_edge();
        n_checks++; if (ValidD !== 1'b0) $display("FAIL fw_bubble got %b want 0", ValidD); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || FetchStall !== 1'b1)
                $display("FAIL fw_drop_addr[%0d] got %b/%h/%b want 1/00000020/1", i, imem_req, imem_addr, FetchStall); else n_pass++;
            next_edge();
        end
        drive(32'h80, 1'b1, 32'hBAD0_0020, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h20) $display("FAIL fw_ack_addr got %h want 00000020", imem_addr); else n_pass++;
        next_edge();
        n_checks++; if (ValidD !== 1'b0 || InstrD === 32'hBAD0_0020) $display("FAIL fw_dropped got %h/%b want bubble", InstrD, ValidD); else n_pass++;
        drive(32'h80, 1'b1, 32'h8888_0080, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("FAIL fw_target got %b/%h want 1/00000080", imem_req, imem_addr); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'h8888_0080 || PCPlus4D !== 32'h84 || ValidD !== 1'b1)
            $display("FAIL fw_target_ifid got %h/%h/%b want 88880080/00000084/1", InstrD, PCPlus4D, ValidD); else n_pass++;
    endtask

    task automatic test_flush_stall_ack();
        drive(32'h30, 1'b1, 32'h3333_0030, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (FetchStall !== 1'b0) $display("FAIL fs_fstall got %b want 0", FetchStall); else n_pass++;
        next_edge();
        n_checks++; if (ValidD !== 1'b0 || InstrD !== NOP) $display("FAIL fs_bubble got %h/%b want %h/0", InstrD, ValidD, NOP); else n_pass++;
        drive(32'h30, 1'b1, 32'h3434_0030, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) $display("FAIL fs_stay_fetch got %b/%h want 1/00000030", imem_req, imem_addr); else n_pass++;
        next_edge();
        n_checks++; if (InstrD !== 32'h3434_0030 || ValidD !== 1'b1) $display("FAIL fs_after got %h/%b want 34340030/1", InstrD, ValidD); else n_pass++;
    endtask

    task automatic test_timeout_reset();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            next_edge();
            if (i == 15) begin
                n_checks++; if (imem_err !== 1'b0) $display("FAIL to_early got %b want 0", imem_err); else n_pass++;
            end
            if (i == 16 || i == 20) begin
                n_checks++; if (imem_err !== 1'b1) $display("FAIL to_set[%0d] got %b want 1", i, imem_err); else n_pass++;
            end
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (imem_err !== 1'b0 || imem_req !== 1'b0) $display("FAIL to_rst got err=%b req=%b want 0/0", imem_err, imem_req); else n_pass++;
        n_checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCPlus4D !== 32'h0)
            $display("FAIL to_rst_ifid got %h/%h/%b want %h/0/0", InstrD, PCPlus4D, ValidD, NOP); else n_pass++;
        next_edge();
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_err !== 1'b0) $display("FAIL to_release got req=%b err=%b want 1/0", imem_req, imem_err); else n_pass++;
        next_edge();
    endtask

    // Reference model: instruction memory contents and transaction-level fetch bookkeeping.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } ent_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic test_random();
        ent_t        parked[$];
        logic        dropping;
        logic [31:0] drop_a;
        int          waited;
        logic        err_m;
        logic [31:0] m_instr;
        logic [31:0] m_pcp4;
        logic        m_valid;
        logic [31:0] pc;
        int          age;
        int          lat;
        logic        ack;
        logic        st;
        logic        fl;
        logic        req_e;
        logic [31:0] addr_e;
        logic        fs_e;
        logic [31:0] rd;

        reset = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_edge();
        reset = 1'b1;
        dropping = 1'b0; drop_a = 32'h0; waited = 0; err_m = 1'b0;
        m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0;
        pc = 32'h0; age = 0; lat = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            st     = ($urandom_range(0, 3) == 0);
            fl     = ($urandom_range(0, 9) == 0);
            req_e  = (parked.size() == 0);
            addr_e = dropping ? drop_a : pc;
            if (req_e) begin
                if (age == 0) lat = $urandom_range(0, 3);
                ack = (age == lat);
            end else begin
                ack = 1'b0;
            end
            rd = mem_word(addr_e);
            drive(pc, ack, rd, st, fl);
            fs_e = (parked.size() != 0) || dropping || (!ack && !fl);

            @(negedge clk);
            n_checks++; if (imem_req !== req_e) $display("FAIL rnd_req[%0d] got %b want %b", cyc, imem_req, req_e); else n_pass++;
            if (req_e) begin
                n_checks++; if (imem_addr !== addr_e) $display("FAIL rnd_addr[%0d] got %h want %h", cyc, imem_addr, addr_e); else n_pass++;
            end
            n_checks++; if (FetchStall !== fs_e) $display("FAIL rnd_fstall[%0d] got %b want %b", cyc, FetchStall, fs_e); else n_pass++;
            n_checks++; if (PCPlus4F !== pc + 32'd4) $display("FAIL rnd_pcp4f[%0d] got %h want %h", cyc, PCPlus4F, pc + 32'd4); else n_pass++;
            n_checks++; if (ValidD !== m_valid || InstrD !== m_instr)
                $display("FAIL rnd_ifid[%0d] got %h/%b want %h/%b", cyc, InstrD, ValidD, m_instr, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++; if (PCPlus4D !== m_pcp4) $display("FAIL rnd_pcp4d[%0d] got %h want %h", cyc, PCPlus4D, m_pcp4); else n_pass++;
            end
            n_checks++; if (imem_err !== err_m) $display("FAIL rnd_err[%0d] got %b want %b", cyc, imem_err, err_m); else n_pass++;

            // Advance the model by the rules: flush first, then stall, then deliver.
            if (parked.size() != 0) begin
                if (fl) begin
                    parked.delete();
                    m_instr = NOP; m_valid = 1'b0;
                end else if (!st) begin
                    m_instr = parked[0].instr; m_pcp4 = parked[0].pcp4; m_valid = 1'b1;
                    parked.delete();
                end
            end else if (dropping) begin
                if (fl || !st) begin
                    m_instr = NOP; m_valid = 1'b0;
                end
                if (ack) dropping = 1'b0;
            end else if (fl) begin
                m_instr = NOP; m_valid = 1'b0;
                if (!ack) begin
                    dropping = 1'b1;
                    drop_a   = pc;
                end
            end else if (st) begin
                if (ack) parked.push_back('{instr: rd, pcp4: pc + 32'd4});
            end else if (ack) begin
                m_instr = rd; m_pcp4 = pc + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end

            if (req_e && !ack) waited = (waited < TMO) ? waited + 1 : TMO;
            else waited = 0;
            if (waited == TMO) err_m = 1'b1;

            if (req_e && !ack) age++;
            else age = 0;

            if (fl) pc = 32'($urandom_range(0, 1023)) << 2;
            else if (!fs_e) pc = pc + 32'd4;

            next_edge();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_on_ack();
        test_flush_during_wait();
        test_flush_stall_ack();
        test_timeout_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
